// File: rtl/egress_port.sv
// -----------------------------------------------------------------------------
// egress_port
//
// Per-output egress stage of the 4x4 switch. Accepts the 33-bit tagged word
// stream from the output arbitration daemon (bit 32 = valid, bits 31:0 = data),
// buffers accepted words in a show-ahead FIFO and presents the head word to
// the external sink on a valid/ready handshake.
//
// Ports:
//   clk          single clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   in_word      tagged word from the daemon {valid, data[31:0]}
//   out_data     head-of-FIFO word (show-ahead, always mem[rd_ptr])
//   out_valid    FIFO holds at least one word
//   out_ready    sink accepts out_data this cycle
//   almost_full  registered, occupancy >= AF_LEVEL
//   level        registered occupancy, 0..DEPTH
//   word_count   saturating count of words written into the FIFO
//   drop_count   saturating count of words discarded because the FIFO was full
//
// Configuration macro:
//   EGRESS_DROP_CNT_EN  when defined, drop_count counts discarded words;
//                       when undefined, drop_count is tied to zero and its
//                       counter is not built. Dropping itself is unaffected.
// -----------------------------------------------------------------------------
module egress_port #(
    parameter int DEPTH    = 8,
    parameter int AW       = 3,
    parameter int AF_LEVEL = 6,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [32:0]      in_word,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             almost_full,
    output logic [AW:0]      level,
    output logic [CNT_W-1:0] word_count,
    output logic [CNT_W-1:0] drop_count
);

    localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];
    localparam logic [AW:0] AF_THRESH  = AF_LEVEL[AW:0];

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ACTIVE,
        ST_FULL
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [31:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    logic           push_req;
    logic           pop;
    logic           push_ok;
    logic [AW:0]    level_next;

    // Handshake outputs come straight from the occupancy state so that a
    // word written into an empty FIFO only becomes visible after the edge.
    always_comb begin
        out_valid = (state != ST_EMPTY);
        out_data  = mem[rd_ptr];
    end

    // Push/pop decision and next occupancy. A full FIFO that pops in the
    // same cycle frees a slot, so the incoming word is still accepted.
    always_comb begin
        push_req   = in_word[32];
        pop        = out_valid & out_ready;
        push_ok    = push_req & ((level != FULL_LEVEL) | pop);
        level_next = level;
        if (push_ok && !pop) begin
            level_next = level + 1'b1;
        end else if (pop && !push_ok) begin
            level_next = level - 1'b1;
        end
    end

    // Next state is derived from the next occupancy so that the state
    // can never disagree with level.
    always_comb begin
        state_next = ST_ACTIVE;
        if (level_next == '0) begin
            state_next = ST_EMPTY;
        end else if (level_next == FULL_LEVEL) begin
            state_next = ST_FULL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Storage array is deliberately not reset; its contents are only
    // observable through out_data, which is qualified by out_valid.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr] <= in_word[31:0];
        end
    end

    // Pointers, occupancy, almost-full flag and accepted-word counter.
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            almost_full <= 1'b0;
            word_count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (word_count != '1) begin
                    word_count <= word_count + 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level       <= level_next;
            almost_full <= (level_next >= AF_THRESH);
        end
    end

`ifdef EGRESS_DROP_CNT_EN
    logic             drop;
    logic [CNT_W-1:0] drop_q;

    // A word is dropped only when it is valid and could not be accepted,
    // i.e. the FIFO was full and nothing left it this cycle.
    assign drop = push_req & ~push_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else if (drop && (drop_q != '1)) begin
            drop_q <= drop_q + 1'b1;
        end
    end

    assign drop_count = drop_q;
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_egress_port.sv
// -----------------------------------------------------------------------------
// tb_egress_port
//
// Scoreboard bench for egress_port. The driver issues directed vectors and
// pushes every word it expects the FIFO to accept into a queue; a separate
// monitor pops and compares whenever the sink handshake completes, and also
// checks that the head word holds steady while the sink stalls. A second
// instance with 4-bit counters runs on the same stimulus to exercise
// counter saturation.
// -----------------------------------------------------------------------------
module tb_egress_port;

    localparam int DEPTH    = 8;
    localparam int AW       = 3;
    localparam int AF_LEVEL = 6;
    localparam int CNT_W    = 16;

    logic             clk;
    logic             rst;
    logic [32:0]      in_word;
    logic             out_ready;
    logic [31:0]      out_data;
    logic             out_valid;
    logic             almost_full;
    logic [AW:0]      level;
    logic [CNT_W-1:0] word_count;
    logic [CNT_W-1:0] drop_count;

    logic [31:0]      sat_data;
    logic             sat_valid;
    logic             sat_af;
    logic [AW:0]      sat_level;
    logic [3:0]       sat_word_count;
    logic [3:0]       sat_drop_count;

    int               checks;
    int               errors;

    logic [31:0]      sb[$];
    int               m_level;
    int               m_words;
    int               m_drops;
    int               m_words4;

    egress_port #(
        .DEPTH(DEPTH), .AW(AW), .AF_LEVEL(AF_LEVEL), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .in_word(in_word),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .almost_full(almost_full), .level(level),
        .word_count(word_count), .drop_count(drop_count)
    );

    egress_port #(
        .DEPTH(DEPTH), .AW(AW), .AF_LEVEL(AF_LEVEL), .CNT_W(4)
    ) dut_sat (
        .clk(clk), .rst(rst), .in_word(in_word),
        .out_data(sat_data), .out_valid(sat_valid), .out_ready(out_ready),
        .almost_full(sat_af), .level(sat_level),
        .word_count(sat_word_count), .drop_count(sat_drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int expDrops();
`ifdef EGRESS_DROP_CNT_EN
        return m_drops;
`else
        return 0;
`endif
    endfunction

    task automatic checkOutput(input string name);
        checkValue({name, "_level"}, 64'(level), 64'(m_level));
        checkValue({name, "_valid"}, 64'(out_valid), 64'(m_level != 0));
        checkValue({name, "_af"}, 64'(almost_full), 64'(m_level >= AF_LEVEL));
        checkValue({name, "_words"}, 64'(word_count), 64'(m_words));
        checkValue({name, "_drops"}, 64'(drop_count), 64'(expDrops()));
        checkValue({name, "_words4"}, 64'(sat_word_count), 64'(m_words4));
    endtask

    // Drive one cycle of stimulus and advance the reference model for the
    // coming edge; returns #1 after that edge.
    task automatic applyStimulus(input logic v, input logic [31:0] data, input logic ready);
        bit mpop;
        bit accept;
        in_word   = {v, data};
        out_ready = ready;
        mpop   = (m_level != 0) && ready;
        accept = v && ((m_level < DEPTH) || mpop);
        if (accept) begin
            sb.push_back(data);
            if (m_words < 65535) m_words++;
            if (m_words4 < 15) m_words4++;
        end else if (v) begin
            if (m_drops < 65535) m_drops++;
        end
        m_level = m_level + int'(accept) - int'(mpop);
        @(posedge clk);
        #1;
    endtask

    // One reset cycle; a valid word is offered during it and must be ignored.
    task automatic doReset();
        rst       = 1'b1;
        in_word   = {1'b1, 32'h0000_0077};
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_word  = '0;
        sb.delete();
        m_level  = 0;
        m_words  = 0;
        m_drops  = 0;
        m_words4 = 0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 4 * DEPTH && m_level != 0; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b1);
        end
        checkValue({name, "_drained_level"}, 64'(level), 64'd0);
        checkValue({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    // Monitor: compare the head word on every completed handshake and
    // verify the outputs hold while the sink stalls.
    initial begin : monitor
        logic        stall_prev;
        logic [31:0] stall_data;
        logic [31:0] exp;
        stall_prev = 1'b0;
        stall_data = '0;
        forever begin
            @(negedge clk);
            if (stall_prev) begin
                checks++;
                if (!out_valid || out_data !== stall_data) begin
                    errors++;
                    $display("[TB] FAIL stall_hold: got valid=%0b data=0x%0h expected valid=1 data=0x%0h",
                             out_valid, out_data, stall_data);
                end
            end
            if (!rst && out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL pop_data: got 0x%0h expected no word", out_data);
                end else begin
                    exp = sb.pop_front();
                    if (out_data !== exp) begin
                        errors++;
                        $display("[TB] FAIL pop_data: got 0x%0h expected 0x%0h", out_data, exp);
                    end
                end
            end
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                stall_prev = out_valid && !out_ready;
                stall_data = out_data;
            end
        end
    end

    initial begin : driver
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_word   = '0;
        out_ready = 1'b0;
        m_level   = 0;
        m_words   = 0;
        m_drops   = 0;
        m_words4  = 0;
        @(posedge clk);
        #1;
        doReset();
        $display("[TB] reset state");
        checkOutput("reset");

        $display("[TB] single word");
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0);
        checkValue("single_valid", 64'(out_valid), 64'd1);
        checkValue("single_data", 64'(out_data), 64'hDEAD_BEEF);
        checkValue("single_level", 64'(level), 64'd1);
        checkValue("single_words", 64'(word_count), 64'd1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkValue("single_valid_after_pop", 64'(out_valid), 64'd0);
        checkValue("single_level_after_pop", 64'(level), 64'd0);

        $display("[TB] fill to full and drop");
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 32'(i), 1'b0);
            checkValue("fill_af", 64'(almost_full), 64'(i >= 5));
        end
        checkOutput("fill");
        checkValue("fill_level", 64'(level), 64'd8);
        checkValue("fill_words", 64'(word_count), 64'd8);
`ifdef EGRESS_DROP_CNT_EN
        checkValue("fill_drops", 64'(drop_count), 64'd2);
`else
        checkValue("fill_drops", 64'(drop_count), 64'd0);
`endif
        drain("fill");

        $display("[TB] push and pop at full");
        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 32'(i), 1'b0);
        end
        applyStimulus(1'b1, 32'h0000_00A5, 1'b1);
        checkValue("full_pp_level", 64'(level), 64'd8);
        checkValue("full_pp_drops", 64'(drop_count), 64'd0);
        checkValue("full_pp_words", 64'(word_count), 64'd9);
        checkOutput("full_pp");
        drain("full_pp");

        $display("[TB] streaming with backpressure");
        doReset();
        for (int i = 1; i <= 100; i++) begin
            applyStimulus(1'b1, 32'(i), (i % 2) == 1);
        end
        checkOutput("stream");
`ifdef EGRESS_DROP_CNT_EN
        checkValue("stream_total", 64'(word_count) + 64'(drop_count), 64'd100);
`else
        checkValue("stream_total", 64'(word_count) + 64'(m_drops), 64'd100);
`endif
        drain("stream");

        $display("[TB] saturation and reset");
        doReset();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 32'h1000 + 32'(i), 1'b1);
        end
        checkValue("sat_words4", 64'(sat_word_count), 64'd15);
        checkValue("sat_words16", 64'(word_count), 64'd20);
        applyStimulus(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h2000 + 32'(i), 1'b0);
        end
        checkValue("sat_level3", 64'(level), 64'd3);
        doReset();
        checkValue("rst_level", 64'(level), 64'd0);
        checkValue("rst_valid", 64'(out_valid), 64'd0);
        checkValue("rst_words", 64'(word_count), 64'd0);
        checkValue("rst_drops", 64'(drop_count), 64'd0);
        checkValue("rst_words4", 64'(sat_word_count), 64'd0);
        checkOutput("rst");

        applyStimulus(1'b1, 32'h0BAD_F00D, 1'b0);
        checkValue("post_rst_data", 64'(out_data), 64'h0BAD_F00D);
        drain("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/egress_port.md
# egress_port

Per-output egress stage of the 4x4 switch. Sits directly downstream of each output arbitration daemon and consumes the 33-bit tagged word stream it produces (bit 32 = valid, bits 31:0 = data). It buffers words in a show-ahead FIFO and presents them to the external sink on a valid/ready handshake. It exposes an almost-full flag for upstream throttling, plus accepted/dropped word counters for monitoring.

## Interface
- DEPTH, 8, FIFO entries; power of two, minimum 2
- AW, 3, FIFO address width; equals log2(DEPTH)
- AF_LEVEL, 6, occupancy at or above which `almost_full` asserts; range 1..DEPTH
- CNT_W, 16, width of the statistics counters

Ports:
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- in_word  in  33  tagged word from the output daemon; bit 32 = valid, 31:0 = data
- out_data  out  32  head-of-FIFO word
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  sink accepts `out_data` this cycle
- almost_full  out  1  occupancy >= AF_LEVEL
- level  out  AW+1  current occupancy, 0..DEPTH
- word_count  out  CNT_W  words accepted into the FIFO, saturating
- drop_count  out  CNT_W  words discarded due to full FIFO, saturating

## Operation
- Define push_req = in_word[32] and pop = out_valid & out_ready.
- **Push acceptance.** A push is accepted if push_req and (level < DEPTH or pop). A full FIFO that pops in the same cycle accepts the push.
- **Drop.** If push_req and level == DEPTH and not pop, the word is discarded and drop_count increments.
- **Write.** An accepted word is written at wr_ptr, and wr_ptr increments modulo DEPTH. word_count increments.
- **Read.** On pop, rd_ptr increments modulo DEPTH.
- **Show-ahead.** out_data always equals mem[rd_ptr]. out_valid = (level != 0).
- **Occupancy.** level increments on accepted push without pop, decrements on pop without push, and is unchanged when both or neither occur.
- **Empty with push.** With level == 0 and push_req, the word is written and visible at the outputs next cycle. It never passes through combinationally.
- **Counter saturation.** Both counters saturate at 2^CNT_W-1 and never wrap.
- **Data-only reset.** `in_word[31:0]` with valid = 0 is ignored entirely.
- **Occupancy FSM.** Three states, each derived from the next level value, so the state always matches level:
  - EMPTY (level = 0)
  - ACTIVE (0 < level < DEPTH)
  - FULL (level = DEPTH)
- **FSM transitions:**
  - EMPTY→ACTIVE on accepted push.
  - ACTIVE→FULL when level reaches DEPTH.
  - FULL→ACTIVE on pop without push.
  - ACTIVE→EMPTY when level reaches 0.
- **Sink handshake.** The sink may hold out_ready high continuously. out_data/out_valid must stay stable while out_valid & !out_ready.

## Timing
- Reset values: out_valid=0, almost_full=0, level=0, word_count=0, drop_count=0, pointers=0, state EMPTY.
- out_data after reset is don't-care; the memory array is not reset.
- **Reset mid-operation.** Reset empties the FIFO in one cycle. Pending contents are lost and no drop is counted. A push_req or pop during the reset cycle is ignored.
- **Latency.** A push accepted at edge n into an empty FIFO gives out_valid=1 and out_data equal to that word after edge n.
- **Throughput.** One word per cycle in and out sustained.
- **Registered outputs.** almost_full, level, and counters are registered and reflect the state after the current edge.

## Configuration
- Macro: `EGRESS_DROP_CNT_EN`.
- **Defined:** drop_count operates as above.
- **Undefined:** drop_count is tied to 0 and its counter logic is omitted. Dropping still occurs identically, and word_count is unaffected.

## Test plan
- **Reset then single word.** Reset, then one word 0xDEADBEEF with valid, out_ready=0:
  - Next cycle: out_valid=1, out_data=0xDEADBEEF, level=1, word_count=1.
  - Set out_ready=1: one cycle later out_valid=0, level=0.
- **Fill to full and drop.** 10 consecutive valid words 0..9 with out_ready=0, DEPTH=8:
  - level=8, almost_full asserted when level=6.
  - drop_count=2, word_count=8.
  - Drain yields 0..7 in order.
- **Simultaneous push and pop at full.** Full FIFO (0..7), then valid word 0xA5 with out_ready=1:
  - Pop of 0 and push of 0xA5 are both accepted; level stays 8, drop_count is unchanged.
  - Drain ends with 0xA5.
- **Streaming with backpressure.** Continuous valid words 1..100, out_ready toggling 1,0,1,0:
  - Received sequence equals sent sequence minus counted drops; word_count + drop_count = 100.
  - out_data stays stable while stalled.
- **Saturation and reset.** CNT_W=4, 20 accepted words with out_ready=1 → word_count=15. Assert rst for one cycle mid-stream with level=3 → level=0, out_valid=0, both counters=0 after the edge.
- **Macro undefined.** Rerun scenario 2 without `EGRESS_DROP_CNT_EN` → drop_count=0, all other outputs identical.
